// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - IF/MEM single-bus arbiter with registered bus signals and stall vector
// Optional bus-busy abort: define ARB_TIMEOUT_EN.
module bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_sel,
    output logic [31:0] mem_rdata,
    output logic        mem_ack,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [5:0]  stall_out,
    output logic        arb_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2
    } state_t;

    localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;
    localparam logic [5:0]  STALL_MEM  = 6'b011111;
    localparam logic [5:0]  STALL_IF   = 6'b000011;

    state_t state;
    state_t state_nxt;
    logic   last_grant_mem;
    logic   if_elig;
    logic   mem_elig;
    logic   grant_if;
    logic   grant_mem;
    logic   done;
    logic   abort;
    logic   timeout_hit;

    // A request whose ack is showing this cycle has already been served.
    assign if_elig  = if_req & ~if_ack;
    assign mem_elig = mem_req & ~mem_ack;

`ifdef ARB_TIMEOUT_EN
    logic [15:0] busy_cnt;

    assign timeout_hit = (state != IDLE) && (busy_cnt == 16'(TIMEOUT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_cnt <= '0;
        end else if (grant_if || grant_mem) begin
            busy_cnt <= '0;
        end else if (state != IDLE && !bus_ack && !timeout_hit) begin
            busy_cnt <= busy_cnt + 16'd1;
        end
    end
`else
    logic [15:0] unused_timeout;

    assign unused_timeout = 16'(TIMEOUT);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the port that did not win last time goes first.
                if (mem_elig && (!if_elig || !last_grant_mem)) begin
                    grant_mem = 1'b1;
                    state_nxt = MEM_BUSY;
                end else if (if_elig) begin
                    grant_if  = 1'b1;
                    state_nxt = IF_BUSY;
                end
            end
            IF_BUSY, MEM_BUSY: begin
                if (timeout_hit) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else if (bus_ack) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_mem <= 1'b0;
            bus_req        <= 1'b0;
            bus_we         <= 1'b0;
            bus_addr       <= '0;
            bus_wdata      <= '0;
            bus_sel        <= '0;
            if_rdata       <= '0;
            mem_rdata      <= '0;
            if_ack         <= 1'b0;
            mem_ack        <= 1'b0;
            arb_err        <= 1'b0;
        end else begin
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;
            arb_err <= 1'b0;
            if (grant_if) begin
                last_grant_mem <= 1'b0;
                bus_req        <= 1'b1;
                bus_we         <= 1'b0;
                bus_addr       <= if_addr;
                bus_wdata      <= '0;
                bus_sel        <= 4'hF;
            end else if (grant_mem) begin
                last_grant_mem <= 1'b1;
                bus_req        <= 1'b1;
                bus_we         <= mem_we;
                bus_addr       <= mem_addr;
                bus_wdata      <= mem_wdata;
                bus_sel        <= mem_sel;
            end
            if (done || abort) begin
                bus_req <= 1'b0;
                arb_err <= abort;
                if (state == IF_BUSY) begin
                    if_ack   <= 1'b1;
                    if_rdata <= abort ? ABORT_DATA : bus_rdata;
                end else begin
                    mem_ack <= 1'b1;
                    if (abort) begin
                        mem_rdata <= ABORT_DATA;
                    end else if (!bus_we) begin
                        mem_rdata <= bus_rdata;
                    end
                end
            end
        end
    end

    // Pipeline must freeze immediately, so this is not registered.
    always_comb begin
        stall_out = 6'b000000;
        if (rst) begin
            if (mem_elig) begin
                stall_out = STALL_MEM;
            end else if (if_elig) begin
                stall_out = STALL_IF;
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed vector bench for bus_arbiter
module tb_bus_arbiter;

    localparam int TMO = 4;
    localparam logic [5:0] S_M = 6'b011111;
    localparam logic [5:0] S_I = 6'b000011;
    localparam logic [5:0] S_0 = 6'b000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_sel;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic [5:0]  stall_out;
    logic        arb_err;

    int total = 0;
    int bad   = 0;

    bus_arbiter #(.TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_sel   (mem_sel),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_sel   (bus_sel),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .stall_out (stall_out),
        .arb_err   (arb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        mreq;
        logic        mwe;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [3:0]  msel;
        logic        back;
        logic [31:0] brdata;
        logic        breq;
        logic        bwe;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic [3:0]  bsel;
        logic        iack;
        logic        mack;
        logic [5:0]  stall;
        logic [31:0] irdata;
        logic [31:0] mrdata;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ireq, input logic [31:0] iaddr, input logic mreq, input logic mwe,
                       input logic [31:0] maddr, input logic [31:0] mwdata, input logic [3:0] msel,
                       input logic back, input logic [31:0] brdata,
                       input logic breq, input logic bwe, input logic [31:0] baddr, input logic [31:0] bwdata,
                       input logic [3:0] bsel, input logic iack, input logic mack, input logic [5:0] stall,
                       input logic [31:0] irdata, input logic [31:0] mrdata);
        vec_t v;
        v = '{ireq, iaddr, mreq, mwe, maddr, mwdata, msel, back, brdata,
              breq, bwe, baddr, bwdata, bsel, iack, mack, stall, irdata, mrdata};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        if_req    = 1'b0;
        if_addr   = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_sel   = '0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " bus_req"},   32'(bus_req),   0);
        check({tag, " bus_we"},    32'(bus_we),    0);
        check({tag, " bus_addr"},  bus_addr,       0);
        check({tag, " bus_wdata"}, bus_wdata,      0);
        check({tag, " bus_sel"},   32'(bus_sel),   0);
        check({tag, " if_rdata"},  if_rdata,       0);
        check({tag, " mem_rdata"}, mem_rdata,      0);
        check({tag, " acks"},      32'({if_ack, mem_ack, arb_err}), 0);
        check({tag, " stall"},     32'(stall_out), 0);
    endtask

    initial begin
        drive_idle();
        rst = 1'b0;

        //   ireq iaddr mreq we maddr mwdata sel back brdata     | breq we baddr bwdata sel  iack mack stall irdata        mrdata
        add(1, 32'h10, 0, 0, 0,      0,      0,   0, 0,            0, 0, 0,      0,      0,   0, 0, S_I, 0,            0);
        add(1, 32'h10, 0, 0, 0,      0,      0,   0, 0,            1, 0, 32'h10, 0,      4'hF,0, 0, S_I, 0,            0);
        add(1, 32'h10, 0, 0, 0,      0,      0,   0, 0,            1, 0, 32'h10, 0,      4'hF,0, 0, S_I, 0,            0);
        add(1, 32'h10, 0, 0, 0,      0,      0,   1, 32'h34011100, 1, 0, 32'h10, 0,      4'hF,0, 0, S_I, 0,            0);
        add(1, 32'h10, 0, 0, 0,      0,      0,   0, 0,            0, 0, 0,      0,      0,   1, 0, S_0, 32'h34011100, 0);
        add(0, 0,      0, 0, 0,      0,      0,   0, 0,            0, 0, 0,      0,      0,   0, 0, S_0, 32'h34011100, 0);
        add(1, 32'h20, 1, 0, 32'h100,0,      4'hF,0, 0,            0, 0, 0,      0,      0,   0, 0, S_M, 32'h34011100, 0);
        add(1, 32'h20, 1, 0, 32'h100,0,      4'hF,1, 32'hAAAA5555, 1, 0, 32'h100,0,      4'hF,0, 0, S_M, 32'h34011100, 0);
        add(1, 32'h20, 1, 0, 32'h100,0,      4'hF,0, 0,            0, 0, 0,      0,      0,   0, 1, S_I, 32'h34011100, 32'hAAAA5555);
        add(1, 32'h20, 0, 0, 0,      0,      0,   1, 32'h11112222, 1, 0, 32'h20, 0,      4'hF,0, 0, S_I, 32'h34011100, 32'hAAAA5555);
        add(1, 32'h20, 0, 0, 0,      0,      0,   0, 0,            0, 0, 0,      0,      0,   1, 0, S_0, 32'h11112222, 32'hAAAA5555);
        add(0, 0,      1, 1, 32'h200,32'hABCD,4'h3,0, 0,           0, 0, 0,      0,      0,   0, 0, S_M, 32'h11112222, 32'hAAAA5555);
        add(0, 0,      1, 1, 32'h200,32'hABCD,4'h3,0, 0,           1, 1, 32'h200,32'hABCD,4'h3,0, 0, S_M, 32'h11112222, 32'hAAAA5555);
        add(0, 0,      1, 1, 32'h200,32'hABCD,4'h3,0, 0,           1, 1, 32'h200,32'hABCD,4'h3,0, 0, S_M, 32'h11112222, 32'hAAAA5555);
        add(0, 0,      1, 1, 32'h200,32'hABCD,4'h3,1, 32'hFFFFFFFF,1, 1, 32'h200,32'hABCD,4'h3,0, 0, S_M, 32'h11112222, 32'hAAAA5555);
        add(0, 0,      0, 0, 0,      0,      0,   0, 0,            0, 0, 0,      0,      0,   0, 1, S_0, 32'h11112222, 32'hAAAA5555);
        add(1, 32'h30, 1, 0, 32'h300,0,      4'hF,0, 0,            0, 0, 0,      0,      0,   0, 0, S_M, 32'h11112222, 32'hAAAA5555);
        add(1, 32'h30, 1, 0, 32'h300,0,      4'hF,1, 32'h12345678, 1, 0, 32'h30, 0,      4'hF,0, 0, S_M, 32'h11112222, 32'hAAAA5555);
        add(1, 32'h30, 1, 0, 32'h300,0,      4'hF,0, 0,            0, 0, 0,      0,      0,   1, 0, S_M, 32'h12345678, 32'hAAAA5555);
        add(0, 0,      1, 0, 32'h300,0,      4'hF,1, 32'h87654321, 1, 0, 32'h300,0,      4'hF,0, 0, S_M, 32'h12345678, 32'hAAAA5555);
        add(0, 0,      0, 0, 0,      0,      0,   0, 0,            0, 0, 0,      0,      0,   0, 1, S_0, 32'h12345678, 32'h87654321);
        add(0, 0,      0, 0, 0,      0,      0,   1, 32'hDEAD0000, 0, 0, 0,      0,      0,   0, 0, S_0, 32'h12345678, 32'h87654321);
        add(0, 0,      0, 0, 0,      0,      0,   0, 0,            0, 0, 0,      0,      0,   0, 0, S_0, 32'h12345678, 32'h87654321);

        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            if_req    = vecs[i].ireq;
            if_addr   = vecs[i].iaddr;
            mem_req   = vecs[i].mreq;
            mem_we    = vecs[i].mwe;
            mem_addr  = vecs[i].maddr;
            mem_wdata = vecs[i].mwdata;
            mem_sel   = vecs[i].msel;
            bus_ack   = vecs[i].back;
            bus_rdata = vecs[i].brdata;
            #1;
            check($sformatf("row%0d bus_req", i),   32'(bus_req),   32'(vecs[i].breq));
            check($sformatf("row%0d if_ack", i),    32'(if_ack),    32'(vecs[i].iack));
            check($sformatf("row%0d mem_ack", i),   32'(mem_ack),   32'(vecs[i].mack));
            check($sformatf("row%0d stall", i),     32'(stall_out), 32'(vecs[i].stall));
            check($sformatf("row%0d if_rdata", i),  if_rdata,       vecs[i].irdata);
            check($sformatf("row%0d mem_rdata", i), mem_rdata,      vecs[i].mrdata);
            check($sformatf("row%0d arb_err", i),   32'(arb_err),   0);
            if (vecs[i].breq) begin
                check($sformatf("row%0d bus_we", i),    32'(bus_we),  32'(vecs[i].bwe));
                check($sformatf("row%0d bus_addr", i),  bus_addr,     vecs[i].baddr);
                check($sformatf("row%0d bus_wdata", i), bus_wdata,    vecs[i].bwdata);
                check($sformatf("row%0d bus_sel", i),   32'(bus_sel), 32'(vecs[i].bsel));
            end
        end

        // Reset in the middle of a MEM transfer.
        @(negedge clk);
        drive_idle();
        mem_req  = 1'b1;
        mem_addr = 32'h400;
        mem_sel  = 4'hF;
        @(negedge clk);
        #1;
        check("midrst busy bus_req", 32'(bus_req), 1);
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst     = 1'b1;
        mem_req = 1'b0;
        bus_ack = 1'b1;
        bus_rdata = 32'h5555AAAA;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus_ack = 1'b0;
            #1;
            check($sformatf("postrst%0d mem_ack", c), 32'(mem_ack), 0);
            check($sformatf("postrst%0d bus_req", c), 32'(bus_req), 0);
        end
        if_req  = 1'b1;
        if_addr = 32'h500;
        @(negedge clk);
        #1;
        check("postrst if bus_req", 32'(bus_req), 1);
        check("postrst if bus_addr", bus_addr, 32'h500);
        bus_ack   = 1'b1;
        bus_rdata = 32'hCAFE0001;
        @(negedge clk);
        bus_ack = 1'b0;
        if_req  = 1'b0;
        #1;
        check("postrst if_ack", 32'(if_ack), 1);
        check("postrst if_rdata", if_rdata, 32'hCAFE0001);
        check("postrst mem_ack", 32'(mem_ack), 0);

`ifdef ARB_TIMEOUT_EN
        begin
            bit seen;
            seen = 1'b0;
            @(negedge clk);
            drive_idle();
            mem_req  = 1'b1;
            mem_addr = 32'h600;
            mem_sel  = 4'hF;
            for (int c = 0; c < 30 && !seen; c++) begin
                @(negedge clk);
                #1;
                if (mem_ack) seen = 1'b1;
            end
            check("tmo ack seen", 32'(seen), 1);
            check("tmo arb_err", 32'(arb_err), 1);
            check("tmo mem_rdata", mem_rdata, 32'hDEADBEEF);
            check("tmo bus_req", 32'(bus_req), 0);
            check("tmo if_ack", 32'(if_ack), 0);
            mem_req = 1'b0;
            @(negedge clk);
            #1;
            check("tmo err pulse", 32'(arb_err), 0);
            check("tmo idle bus_req", 32'(bus_req), 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Shares one single-port external bus between the instruction-fetch port (IF) and the data-memory port (MEM) of the 5-stage MIPS32 pipeline. It serialises the two request streams with a three-state FSM, drives registered bus signals, returns read data with a one-cycle acknowledge, and emits the pipeline stall vector while either port waits. It sits between the pc_reg/memory stages and the external memory, replacing the dedicated ROM port.

## Interface
Parameters:
- TIMEOUT, 255: bus-busy cycle limit before abort (used only with ARB_TIMEOUT_EN), 1..65535.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Asynchronous, active-low.
- if_req  in  1  fetch request, held until if_ack.
- if_addr  in  32  fetch address.
- if_rdata  out  32  fetched instruction.
- if_ack  out  1  one-cycle fetch completion pulse.
- mem_req  in  1  data request, held until mem_ack.
- mem_we  in  1  1 = write.
- mem_addr  in  32  data address.
- mem_wdata  in  32  write data.
- mem_sel  in  4  byte enables.
- mem_rdata  out  32  load data.
- mem_ack  out  1  one-cycle data completion pulse.
- bus_req  out  1  bus cycle active.
- bus_we  out  1  bus write.
- bus_addr  out  32  bus address.
- bus_wdata  out  32  bus write data.
- bus_sel  out  4  bus byte enables.
- bus_rdata  in  32  slave read data.
- bus_ack  in  1  slave completion, valid one cycle.
- stall_out  out  6  stall vector [0]=pc [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB.
- arb_err  out  1  one-cycle pulse on timeout abort.

## Operation
- FSM: IDLE, IF_BUSY, MEM_BUSY.
- IDLE: if only mem_req -> MEM_BUSY; if only if_req -> IF_BUSY; both -> grant the port not granted last (last_grant resets to IF, so the first tie goes to MEM). last_grant updates on every grant.
- Requests are eligible in IDLE only if the port's ack is not asserted in that same cycle (the acked request is consumed; a still-high req in that cycle is ignored).
- On grant: capture address/controls into bus registers; bus_req=1. IF grant drives bus_we=0, bus_sel=4'hF, bus_wdata=0.
- BUSY: hold all bus outputs stable until bus_ack=1; then bus_req=0, capture bus_rdata into if_rdata or mem_rdata (write: mem_rdata unchanged), pulse matching ack, return to IDLE.
- bus_ack while IDLE is ignored.
- stall_out (combinational from state and inputs): mem_req pending and not acked -> 6'b011111; else if_req pending and not acked -> 6'b000011; else 6'b000000. A MEM wait dominates an IF wait.
- Reset (asserted at any time, including mid-transaction): state IDLE, last_grant=IF, all outputs 0, in-flight transaction dropped without ack.

## Timing
- Request seen in IDLE at cycle 0 -> bus_req=1 from cycle 1.
- bus_ack at cycle k -> ack pulse and rdata valid at cycle k+1; bus_req=0 at k+1; FSM IDLE at k+1.
- Next grant decided at k+1; its bus_req at k+2. Minimum throughput: one transfer per 3 cycles with a zero-wait slave (ack in cycle after bus_req).
- rdata registers hold their value until the next completion for that port.
- Ack pulses are exactly one cycle wide; if_ack and mem_ack never assert together.

## Configuration
- ARB_TIMEOUT_EN defined: 16-bit counter clears on grant, increments each BUSY cycle without bus_ack; on reaching TIMEOUT: bus_req=0, the owning port's ack pulses with rdata=32'hDEADBEEF, arb_err pulses, FSM -> IDLE. bus_ack in the abort cycle is ignored.
- Not defined: no counter; BUSY waits indefinitely; arb_err tied 0.

## Test plan
- Reset: rst=0 mid MEM_BUSY -> all outputs 0 immediately, no mem_ack after rst=1, next if_req granted normally.
- Single fetch: if_req, if_addr=32'h0000_0010, slave acks 2 cycles after bus_req with 32'h3401_1100 -> if_ack at k+1, if_rdata=32'h3401_1100, stall_out=6'b000011 until ack.
- Tie: if_req and mem_req raised together after reset -> MEM granted first (stall 6'b011111), then IF; repeated ties alternate grants.
- Write: mem_we=1, mem_sel=4'b0011, mem_wdata=32'h0000_ABCD -> bus_we=1, bus_sel=4'b0011 held stable until bus_ack; mem_rdata unchanged.
- Held req: if_req kept high through its ack cycle -> single bus transfer, not two.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=4): slave never acks -> arb_err and mem_ack pulse together, mem_rdata=32'hDEADBEEF, FSM back to IDLE.
